// File: rtl/uart_rx_sink.sv
// uart_rx_sink: 8N1 UART receiver for the bring-up harness. It decodes the SoC's
// serial_tx line into bytes on a valid/ready stream. It also flags framing errors
// (a low stop bit) and overruns (a byte lost because the one-entry buffer was full).
module uart_rx_sink #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       cpu_reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Half a bit minus one puts the start-bit sample at the middle of the bit.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic          r_sync1;
  logic          r_sync2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_ovr;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_sh_nxt;
  logic          w_cnt_zero;
  logic          w_deliver;
  logic          w_stop_bad;

  assign w_cnt_zero = (r_cnt == '0);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (cpu_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic for the frame decoder; sampling happens when cnt reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_deliver   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = HALF_M1;
        end
      end
      ST_START: begin
        if (w_cnt_zero) begin
          if (r_sync2) begin
            // Line went back high before mid-bit: glitch, not a start bit.
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = FULL_M1;
            w_idx_nxt   = 3'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (w_cnt_zero) begin
          w_sh_nxt  = {r_sync2, r_sh[7:1]};
          w_cnt_nxt = FULL_M1;
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_STOP: begin
        if (w_cnt_zero) begin
          if (r_sync2) begin
            w_deliver   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_BREAK: begin
        // Stay here while the line is held low, so a break reports one error only.
        if (r_sync2) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame decoder state registers.
  always_ff @(posedge clk) begin
    if (cpu_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_sh    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_sh    <= w_sh_nxt;
    end
  end

  // One-entry output buffer plus single-cycle error pulses.
  always_ff @(posedge clk) begin
    if (cpu_reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= 1'b0;
      if (w_deliver) begin
        // A byte being accepted this cycle frees the slot for the new byte.
        if (!r_valid || rx_ready) begin
          r_data  <= w_sh_nxt;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed bench for uart_rx_sink at 8 clocks per bit: reset values, back-to-back
// frames with latency, glitch rejection, framing error and break, overrun, and
// accept-on-delivery. It also covers reset in the middle of a frame.
module tb_uart_rx_sink;

  localparam int unsigned CPB = 8;
  localparam int unsigned H   = CPB / 2;
  // Edge offset from the first low sample (E) to the edge that raises rx_valid.
  localparam int unsigned LAT = 2 + H + 9 * CPB;

  logic       clk = 1'b0;
  logic       cpu_reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_sink #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .cpu_reset (cpu_reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples just before each rising edge, logging handshakes and pulses.
  logic [7:0] got_q[$];
  int         edge_q[$];
  int         n_ferr    = 0;
  int         n_ovr     = 0;
  int         ferr_edge = -1;
  int         ovr_edge  = -1;

  always @(negedge clk) begin
    #4;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      got_q.push_back(rx_data);
      edge_q.push_back(cyc);
    end
    if (frame_err === 1'b1) begin
      n_ferr++;
      ferr_edge = cyc;
    end
    if (overrun === 1'b1) begin
      n_ovr++;
      ovr_edge = cyc;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives start and data bits, then leaves rx at the stop level. Call at a negedge.
  task automatic send_bits(input logic [7:0] b, input logic stop, output int e);
    rx = 1'b0;
    e  = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int e);
    send_bits(b, stop, e);
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int e1, e2, base, f0, o0;

    cpu_reset = 1'b1;
    rx        = 1'b1;
    rx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  rx_data,   8'h00);
    check("rst_valid", rx_valid,  1'b0);
    check("rst_ferr",  frame_err, 1'b0);
    check("rst_ovr",   overrun,   1'b0);
    check("rst_busy",  busy,      1'b0);
    cpu_reset = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back 0x55, 0xA5 with the consumer always ready.
    base = got_q.size(); f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h55, 1'b1, e1);
    send_frame(8'hA5, 1'b1, e2);
    repeat (20) @(negedge clk);
    check("b2b_count", got_q.size() - base, 2);
    check("b2b_byte0", got_q[base], 8'h55);
    check("b2b_byte1", got_q[base+1], 8'hA5);
    check("b2b_edge0", edge_q[base], e1 + LAT);
    check("b2b_edge1", edge_q[base+1], e2 + LAT);
    check("b2b_ferr",  n_ferr - f0, 0);
    check("b2b_ovr",   n_ovr - o0, 0);

    // Three-cycle glitch: START entered, then abandoned with no output.
    base = got_q.size(); f0 = n_ferr;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_hi", busy, 1'b1);
    rx = 1'b1;
    repeat (H + 3) @(negedge clk);
    check("glitch_busy_lo", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("glitch_nobyte", got_q.size() - base, 0);
    check("glitch_noferr", n_ferr - f0, 0);

    // 0x3C with a low stop bit, then a long break, then a clean 0x81.
    base = got_q.size(); f0 = n_ferr;
    send_frame(8'h3C, 1'b0, e1);
    check("ferr_edge", ferr_edge, e1 + LAT);
    repeat (100) @(negedge clk);
    check("brk_ferr_once", n_ferr - f0, 1);
    check("brk_busy",      busy, 1'b1);
    check("brk_valid",     rx_valid, 1'b0);
    check("brk_nobyte",    got_q.size() - base, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("brk_exit", busy, 1'b0);
    send_frame(8'h81, 1'b1, e1);
    repeat (20) @(negedge clk);
    check("post_brk_count", got_q.size() - base, 1);
    check("post_brk_byte",  got_q[base], 8'h81);
    check("post_brk_ferr",  n_ferr - f0, 1);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    base = got_q.size(); o0 = n_ovr;
    send_frame(8'h11, 1'b1, e1);
    send_frame(8'h22, 1'b1, e2);
    repeat (4) @(negedge clk);
    check("ovr_valid",  rx_valid, 1'b1);
    check("ovr_data",   rx_data, 8'h11);
    check("ovr_count",  n_ovr - o0, 1);
    check("ovr_edge",   ovr_edge, e2 + LAT);
    rx_ready = 1'b1;
    @(negedge clk);
    check("ovr_drained",  rx_valid, 1'b0);
    check("ovr_got",      got_q.size() - base, 1);
    check("ovr_got_byte", got_q[base], 8'h11);

    // Accept the held byte on the very cycle the next one is delivered.
    rx_ready = 1'b0;
    base = got_q.size(); o0 = n_ovr;
    send_frame(8'h11, 1'b1, e1);
    repeat (4) @(negedge clk);
    check("sim_hold", rx_valid, 1'b1);
    send_bits(8'h22, 1'b1, e2);
    repeat (CPB - 2) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    check("sim_data",  rx_data, 8'h22);
    check("sim_valid", rx_valid, 1'b1);
    check("sim_noovr", n_ovr - o0, 0);
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("sim_first", got_q[base], 8'h11);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("sim_count",  got_q.size() - base, 2);
    check("sim_second", got_q[base+1], 8'h22);

    // Reset during data bit 4 of 0xF0, then a clean 0x0F.
    base = got_q.size(); f0 = n_ferr;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    cpu_reset = 1'b1;
    @(negedge clk);
    cpu_reset = 1'b0;
    check("mrst_data",  rx_data,   8'h00);
    check("mrst_valid", rx_valid,  1'b0);
    check("mrst_ferr",  frame_err, 1'b0);
    check("mrst_ovr",   overrun,   1'b0);
    check("mrst_busy",  busy,      1'b0);
    repeat (4 * CPB) @(negedge clk);
    send_frame(8'h0F, 1'b1, e1);
    repeat (20) @(negedge clk);
    check("mrst_count", got_q.size() - base, 1);
    check("mrst_byte",  got_q[base], 8'h0F);
    check("mrst_noferr", n_ferr - f0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx_sink.md
# uart_rx_sink

Synchronous 8N1 UART receiver that decodes the `serial_tx` line driven by the SoC, the far end of the SoC's transmit path. It sits in the simulation and bring-up harness next to the design under test. It turns the serial bitstream back into bytes, presented on a valid/ready stream so a checker or console logger can consume them. It also flags false starts, framing errors and overruns so the console path is verified, not only eyeballed in waveforms.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535
- `clk`  in  1  system clock; all logic on rising edge
- `cpu_reset`  in  1  synchronous, active-high reset
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `rx_data`  out  8  received byte, valid while `rx_valid`=1
- `rx_valid`  out  1  byte available
- `rx_ready`  in  1  consumer accepts byte when `rx_valid`&&`rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: byte completed while buffer full and not being drained
- `busy`  out  1  FSM not in IDLE

## Operation
- `rx` passes through a 2-FF synchronizer (both FFs reset to 1); the FSM sees only `rx_s`, the second FF output.
- Bit counter `cnt` is $clog2(CLKS_PER_BIT) bits wide. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits, filled LSB first (shift right, new bit into bit 7).
- States:
  - IDLE: if `rx_s`=0, go to START and set `cnt`=CLKS_PER_BIT/2-1 (integer division).
  - START: decrement `cnt` each cycle. At `cnt`=0, sample `rx_s`.
    - 1: false start, return to IDLE; no flag, no output.
    - 0: go to DATA with `cnt`=CLKS_PER_BIT-1, `idx`=0.
  - DATA: decrement `cnt`. At `cnt`=0, shift `rx_s` into `sh` and reload `cnt`=CLKS_PER_BIT-1. When `idx`=7 at that sample, go to STOP; otherwise `idx`++.
  - STOP: decrement `cnt`. At `cnt`=0, sample `rx_s`.
    - 1: deliver `sh` (see buffer), go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. Holding the line low (break) yields exactly one `frame_err` and no further starts.
- One-entry output buffer:
  - On delivery with `rx_valid`=0, or with `rx_valid`&&`rx_ready` in the same cycle: load `rx_data`=`sh` and set `rx_valid`=1.
  - On delivery with `rx_valid`=1 and `rx_ready`=0: pulse `overrun`, drop the new byte, keep the old byte and `rx_valid`.
  - Otherwise `rx_valid`&&`rx_ready` clears `rx_valid`.
- `rx_data` is stable while `rx_valid`=1 and not accepted.
- Reset in any state, including mid-frame: FSM goes to IDLE. `cnt`, `idx`, `sh`, `rx_data` are cleared to 0. `rx_valid`, `frame_err`, `overrun`, `busy` are cleared to 0. Synchronizer FFs are set to 1. A frame in flight at reset release is not recovered. A low level after reset is treated as a new start edge.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- Let cycle E be the first rising edge at which the synchronizer samples `rx`=0. `rx_s`=0 is seen by IDLE at E+1, and START is entered at E+2.
- Sample points, with H=CLKS_PER_BIT/2:
  - start: E+1+H
  - data bit i (i=0..7): E+1+H+(i+1)*CLKS_PER_BIT
  - stop: E+1+H+9*CLKS_PER_BIT
- `rx_valid`, `frame_err` and `overrun` assert on the edge after the stop sample, i.e. E+2+H+9*CLKS_PER_BIT.
- `busy` is 1 from entry to START through the cycle the FSM is back in IDLE or BREAK exits. It is 1 while in BREAK.
- Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint is detected. No idle gap is required beyond the second half of the stop bit.
- Tolerated baud mismatch is ±4% at CLKS_PER_BIT≥8. No resynchronization occurs within a frame.

## Test plan
- CLKS_PER_BIT=8, send 0x55 then 0xA5 back-to-back, `rx_ready`=1 → two `rx_valid` pulses carrying 0x55 then 0xA5. First `rx_valid` at E+2+4+72. No `frame_err`, no `overrun`.
- Glitch: `rx` low for 3 cycles, then high → START entered then IDLE. `busy` drops within H+3 cycles. No `rx_valid` or `frame_err`.
- Frame 0x3C with stop bit driven 0 → one `frame_err` pulse, `rx_valid` stays 0. Hold `rx` low for 100 more cycles → still a single pulse. FSM stays in BREAK until `rx`=1, then 0x81 is received correctly.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_valid`=1 with 0x11, and an `overrun` pulse at the end of the 0x22 frame. Raise `rx_ready` → 0x11 accepted, `rx_valid` drops.
- Simultaneous: hold 0x11 unaccepted, assert `rx_ready` exactly on the cycle 0x22 is delivered → no `overrun`, and the next cycle shows `rx_data`=0x22, `rx_valid`=1.
- Assert `cpu_reset` during data bit 4 of 0xF0 for 1 cycle → all outputs 0 the next cycle. A subsequent clean 0x0F frame is received as 0x0F.
